// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the packet-memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

  localparam int unsigned DEF_N         = 4;
  localparam int unsigned DEF_MAX_BEATS = 8;
  localparam int unsigned OH_W          = 16;
  localparam int unsigned OH_IDW        = 4;

  // Encodes a one-hot (or zero) vector of up to OH_W bits into its index.
  function automatic logic [OH_IDW-1:0] onehot2bin(input logic [OH_W-1:0] oh);
    logic [OH_IDW-1:0] id;
    id = '0;
    for (int i = 0; i < OH_W; i++) begin
      if (oh[i]) id = id | OH_IDW'(i);
    end
    return id;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: highest set request at or below ptr,
// otherwise the highest set request overall (wrap-around).
module rr_pick #(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic           win_vld,
  output logic [IDW-1:0] win_id
);

  logic           m_vld;
  logic [IDW-1:0] m_id;
  logic [IDW-1:0] u_id;

  // Ascending scan; later hits overwrite, leaving the highest index found.
  always_comb begin
    win_vld = 1'b0;
    m_vld   = 1'b0;
    m_id    = '0;
    u_id    = '0;
    for (int i = 0; i < N; i++) begin
      if (req[i]) begin
        win_vld = 1'b1;
        u_id    = IDW'(i);
        if (IDW'(i) <= ptr) begin
          m_vld = 1'b1;
          m_id  = IDW'(i);
        end
      end
    end
    win_id = m_vld ? m_id : u_id;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin owner of the packet-memory port with burst locking,
// a MAX_BEATS starvation guard and one turnaround cycle between owners.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned N         = DEF_N,
  parameter int unsigned MAX_BEATS = DEF_MAX_BEATS,
  parameter int unsigned IDW       = $clog2(N),
  parameter int unsigned CW        = $clog2(MAX_BEATS + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [N-1:0]   req,
  input  logic           beat,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           busy,
  output logic           limit_hit
);

  state_t         state_q, state_d;
  logic [CW-1:0]  beat_cnt_q, beat_cnt_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [IDW-1:0] gnt_id_q, gnt_id_d;
  logic           busy_q, busy_d;
  logic           limit_hit_q, limit_hit_d;

  logic           win_vld;
  logic [IDW-1:0] win_id;
  logic [IDW-1:0] owner_id;
  logic           owner_req;
  logic           last_beat;

  rr_pick #(.N(N), .IDW(IDW)) u_pick (
    .req     (req),
    .ptr     (ptr_q),
    .win_vld (win_vld),
    .win_id  (win_id)
  );

  assign owner_id  = IDW'(onehot2bin(OH_W'(gnt_q)));
  assign owner_req = req[owner_id];
  assign last_beat = beat && (beat_cnt_q == CW'(MAX_BEATS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      beat_cnt_q  <= '0;
      ptr_q       <= IDW'(N - 1);
      gnt_q       <= '0;
      gnt_id_q    <= '0;
      busy_q      <= 1'b0;
      limit_hit_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      gnt_id_q    <= gnt_id_d;
      busy_q      <= busy_d;
      limit_hit_q <= limit_hit_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    gnt_id_d    = gnt_id_q;
    busy_d      = busy_q;
    limit_hit_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (en && win_vld) begin
          gnt_d      = N'(1) << win_id;
          gnt_id_d   = win_id;
          busy_d     = 1'b1;
          beat_cnt_d = '0;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        // A dropped request takes precedence over the beat limit.
        if (!owner_req || last_beat) begin
          limit_hit_d = owner_req;
          gnt_d       = '0;
          busy_d      = 1'b0;
          beat_cnt_d  = '0;
          ptr_d       = (owner_id == '0) ? IDW'(N - 1) : owner_id - IDW'(1);
          state_d     = TURN;
        end else if (beat) begin
          beat_cnt_d = beat_cnt_q + CW'(1);
        end
      end
      TURN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign busy      = busy_q;
  assign limit_hit = limit_hit_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert ($onehot0(gnt_q));
      assert (busy_q == (|gnt_q));
      assert (beat_cnt_q <= CW'(MAX_BEATS - 1));
    end
  end

endmodule
